fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 5-stage RISC-V core. It owns the PC register, runs the request/ready handshake to instruction memory, and writes the IF/ID pipeline register. It sits directly downstream of the load-use stall logic: it obeys `pc_write_en` / `if_id_write_en` and the EX-stage branch redirect. A one-entry hold buffer ensures that no fetched instruction is lost while the pipeline is stalled.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`).
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc_write_en` in 1: 0 blocks issuing a new fetch request (stall).
- `if_id_write_en` in 1: 0 holds IF/ID contents (stall).
- `branch_taken` in 1: EX-stage redirect; flushes IF/ID.
- `branch_target` in 32: redirect address; bits[1:0] forced to 0.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_rdata` in 32: instruction; valid in the cycle where `imem_req && imem_ready`.
- `imem_ready` in 1: memory accepts and returns data this cycle.
- `if_id_pc` out 32: PC of the instruction in IF/ID.
- `if_id_instr` out 32: instruction in IF/ID.
- `if_id_valid` out 1: IF/ID holds a real instruction.

## Operation
- Registers:
  - `pc`: address of the outstanding or next request.
  - `redirect_pc`.
  - hold buffer `buf_instr` / `buf_pc` / `buf_valid`.
  - `state`.
- Accept: a cycle with `imem_req && imem_ready`.
- Once `imem_req` is high, `imem_addr` stays stable until accept. A stall never withdraws an outstanding request.
- States:
  - IDLE: entered on reset. `imem_req`=0. Goes to FETCH unconditionally on the next edge.
  - FETCH: `imem_req` = `pc_write_en` OR `pending`. `pending` is set when `imem_req` is high and `imem_ready` is low; it is cleared on accept.
    - On accept, `pc` <= `pc`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
    - If `if_id_write_en`=1, the accepted instruction goes to IF/ID.
    - If `if_id_write_en`=0, the accepted instruction goes to the hold buffer and the state goes to HOLD.
  - HOLD: `imem_req`=0.
    - When `if_id_write_en`=1: IF/ID <= buffer, `buf_valid` <= 0, state goes to FETCH.
  - DISCARD: `imem_req`=1 at the old `pc`, with a redirect pending.
    - On accept, the data is dropped, `pc` <= `redirect_pc`, and the state goes to FETCH.
- IF/ID write, when `if_id_write_en`=1 and there is no flush:
  - If data is available (accept in FETCH, or buffer in HOLD): load `if_id_pc`, `if_id_instr`, and set `if_id_valid`=1.
  - Otherwise: `if_id_instr` <= NOP, `if_id_valid` <= 0, `if_id_pc` unchanged.
- Flush (`branch_taken`=1) has priority over stall, in any state except IDLE:
  - IF/ID <= NOP with `if_id_valid`=0.
  - `buf_valid` <= 0.
  - If a request is outstanding and not accepted this cycle: `redirect_pc` <= target, state goes to DISCARD.
  - Otherwise (no request, or accepted this cycle): data is dropped, `pc` <= target, state goes to FETCH.
  - In DISCARD, a new `branch_taken` overwrites `redirect_pc`. If it coincides with accept, `pc` <= the new target.
- `branch_taken` in IDLE is ignored.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`pc`=RESET_PC.
  - `if_id_pc`=0, `if_id_instr`=NOP, `if_id_valid`=0.
  - `buf_valid`=0, `pending`=0, state=IDLE.
- Deassertion of reset: first `imem_req` in the second cycle after `rst_n` rises.
- Latency: an instruction accepted in cycle N appears on `if_id_*` in cycle N+1 (registered).
- Throughput: with `imem_ready`=1 and no stall, one instruction per cycle.
- Stall: HOLD holds one instruction. No request is issued while the buffer is full.
- When the buffer drains in cycle N, the next request is issued in cycle N+1.
- Redirect: a branch at cycle N (no outstanding request) gives `imem_addr`=target in cycle N+1.
- The target instruction reaches IF/ID no earlier than N+2.
- Reset asserted mid-DISCARD or mid-HOLD clears all state immediately. The redirect is lost.

## Test plan
- Reset, then `imem_ready`=1 constant, RESET_PC=0x100 -> `imem_addr` sequence 0x100, 0x104, 0x108; IF/ID shows 0x100 with `if_id_valid`=1 one cycle after its accept.
- `imem_ready` low 3 cycles at 0x104 -> `imem_addr` stable at 0x104 for 4 cycles; IF/ID gets NOP with `if_id_valid`=0 for 3 cycles.
- `pc_write_en` = `if_id_write_en` = 0 for 2 cycles, coinciding with accept of 0x108 -> 0x108 held in buffer; `imem_req`=0; IF/ID keeps 0x104; 0x108 enters IF/ID on the release edge.
- `branch_taken`, target 0x203, while 0x10C is outstanding and not ready -> DISCARD; 0x10C data dropped when ready; next `imem_addr`=0x200; no 0x10C in IF/ID.
- `branch_taken` in the same cycle as accept and stall -> data dropped, buffer empty, `if_id_valid`=0, next `imem_addr`=target.
- `rst_n` low during DISCARD -> all outputs return to reset values asynchronously; first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage RISC-V core.
// Owns the PC, runs the req/ready handshake to instruction memory and writes
// the IF/ID pipeline register. A one-entry hold buffer keeps an instruction
// accepted during an IF/ID stall, and a DISCARD state drains a request that
// was outstanding when an EX-stage redirect arrived.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_write_en         0 = do not issue a new fetch request
//   if_id_write_en      0 = hold IF/ID contents
//   branch_taken        EX-stage redirect, flushes IF/ID
//   branch_target       redirect address (bits [1:0] ignored)
//   imem_req/imem_addr  fetch request and its address (always the PC)
//   imem_rdata          instruction returned in the accept cycle
//   imem_ready          memory accepts and returns data this cycle
//   if_id_pc/instr/valid IF/ID pipeline register
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write_en,
    input  logic        if_id_write_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0]   buf_instr_q, buf_instr_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
    logic              buf_valid_q, buf_valid_d;
    logic              pending_q, pending_d;
    logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0]   if_id_instr_q, if_id_instr_d;
    logic              if_id_valid_q, if_id_valid_d;

    logic              imem_req_c;
    logic              accept_c;
    logic [XLEN-1:0]   target_c;
    logic              unused_target_bits;

    // Redirect targets are word aligned; the low bits are dropped.
    assign target_c           = {branch_target[XLEN-1:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];

    // Request: a stall only blocks new requests, never an outstanding one.
    always_comb begin
        imem_req_c = 1'b0;
        case (state_q)
            S_FETCH:   imem_req_c = pc_write_en | pending_q;
            S_DISCARD: imem_req_c = 1'b1;
            default:   imem_req_c = 1'b0;
        endcase
    end

    assign accept_c = imem_req_c & imem_ready;

    // Next-state, PC, hold buffer and IF/ID update.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        buf_valid_d   = buf_valid_q;
        pending_d     = pending_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        case (state_q)
            S_IDLE: begin
                // Redirects are ignored until the first fetch is launched.
                state_d = S_FETCH;
                if (if_id_write_en) begin
                    if_id_instr_d = NOP;
                    if_id_valid_d = 1'b0;
                end
            end

            S_FETCH: begin
                if (branch_taken) begin
                    if_id_instr_d = NOP;
                    if_id_valid_d = 1'b0;
                    buf_valid_d   = 1'b0;
                    pending_d     = 1'b0;
                    // An unaccepted request must complete at its old address
                    // before the PC may move to the target.
                    if (imem_req_c && !imem_ready) begin
                        redirect_pc_d = target_c;
                        state_d       = S_DISCARD;
                    end else begin
                        pc_d = target_c;
                    end
                end else if (accept_c) begin
                    pc_d      = pc_q + XLEN'(4);
                    pending_d = 1'b0;
                    if (if_id_write_en) begin
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = imem_rdata;
                        if_id_valid_d = 1'b1;
                    end else begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rdata;
                        buf_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end else begin
                    pending_d = imem_req_c;
                    if (if_id_write_en) begin
                        if_id_instr_d = NOP;
                        if_id_valid_d = 1'b0;
                    end
                end
            end

            S_HOLD: begin
                if (branch_taken) begin
                    // No request is outstanding here, so redirect at once.
                    if_id_instr_d = NOP;
                    if_id_valid_d = 1'b0;
                    buf_valid_d   = 1'b0;
                    pc_d          = target_c;
                    state_d       = S_FETCH;
                end else if (if_id_write_en) begin
                    if_id_pc_d    = buf_pc_q;
                    if_id_instr_d = buf_instr_q;
                    if_id_valid_d = 1'b1;
                    buf_valid_d   = 1'b0;
                    state_d       = S_FETCH;
                end
            end

            S_DISCARD: begin
                if (branch_taken) begin
                    // A newer redirect replaces the pending one.
                    if_id_instr_d = NOP;
                    if_id_valid_d = 1'b0;
                    buf_valid_d   = 1'b0;
                    if (accept_c) begin
                        pc_d    = target_c;
                        state_d = S_FETCH;
                    end else begin
                        redirect_pc_d = target_c;
                    end
                end else begin
                    if (accept_c) begin
                        pc_d    = redirect_pc_q;
                        state_d = S_FETCH;
                    end
                    if (if_id_write_en) begin
                        if_id_instr_d = NOP;
                        if_id_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            redirect_pc_q <= '0;
            buf_instr_q   <= '0;
            buf_pc_q      <= '0;
            buf_valid_q   <= 1'b0;
            pending_q     <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            buf_valid_q   <= buf_valid_d;
            pending_q     <= pending_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imem_req    = imem_req_c;
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against a queue-based
// reference model of the fetch stage (in-flight request, redirect, buffer).
module tb_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0100;
    localparam logic [31:0] NOP_I   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    fetch_unit #(.RESET_PC(RST_PC), .NOP(NOP_I)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fetch stage as "started?", an in-flight request flag,
    // an optional pending redirect, and a hold queue of at most one entry.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    bit          m_started;
    bit          m_inflight;
    bit          m_redirect;
    logic [31:0] m_pc;
    logic [31:0] m_redir_pc;
    ent_t        m_buf[$];
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    bit          m_ifid_valid;

    task automatic model_reset();
        m_started    = 0;
        m_inflight   = 0;
        m_redirect   = 0;
        m_pc         = RST_PC;
        m_redir_pc   = 32'h0;
        m_buf.delete();
        m_ifid_pc    = 32'h0;
        m_ifid_instr = NOP_I;
        m_ifid_valid = 0;
    endtask

    function automatic bit model_req();
        if (!m_started)         return 1'b0;
        if (m_redirect)         return 1'b1;
        if (m_buf.size() != 0)  return 1'b0;
        return pc_write_en || m_inflight;
    endfunction

    task automatic bubble_if_free();
        if (if_id_write_en) begin
            m_ifid_instr = NOP_I;
            m_ifid_valid = 0;
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        bit          req;
        bit          acc;
        logic [31:0] tgt;
        ent_t        e;
        req = model_req();
        acc = req && imem_ready;
        tgt = branch_target & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1;
            bubble_if_free();
        end else if (branch_taken) begin
            m_ifid_instr = NOP_I;
            m_ifid_valid = 0;
            m_buf.delete();
            m_inflight   = 0;
            if (m_redirect) begin
                if (acc) begin
                    m_pc       = tgt;
                    m_redirect = 0;
                end else begin
                    m_redir_pc = tgt;
                end
            end else if (req && !acc) begin
                m_redirect = 1;
                m_redir_pc = tgt;
            end else begin
                m_pc = tgt;
            end
        end else if (m_redirect) begin
            if (acc) begin
                m_pc       = m_redir_pc;
                m_redirect = 0;
            end
            bubble_if_free();
        end else if (m_buf.size() != 0) begin
            if (if_id_write_en) begin
                e = m_buf.pop_front();
                m_ifid_pc    = e.pc;
                m_ifid_instr = e.instr;
                m_ifid_valid = 1;
            end
        end else if (acc) begin
            if (if_id_write_en) begin
                m_ifid_pc    = m_pc;
                m_ifid_instr = imem_rdata;
                m_ifid_valid = 1;
            end else begin
                e.pc    = m_pc;
                e.instr = imem_rdata;
                m_buf.push_back(e);
            end
            m_pc       = m_pc + 32'd4;
            m_inflight = 0;
        end else begin
            m_inflight = req;
            bubble_if_free();
        end
    endtask

    task automatic check_outputs();
        check("imem_req",    32'(imem_req),    32'(model_req()));
        check("imem_addr",   imem_addr,        m_pc);
        check("if_id_pc",    if_id_pc,         m_ifid_pc);
        check("if_id_instr", if_id_instr,      m_ifid_instr);
        check("if_id_valid", 32'(if_id_valid), 32'(m_ifid_valid));
    endtask

    task automatic randomize_inputs(input int br_pct);
        pc_write_en    = ($urandom_range(0, 4) != 0);
        if_id_write_en = ($urandom_range(0, 3) != 0);
        branch_taken   = ($urandom_range(0, 99) < br_pct);
        case ($urandom_range(0, 3))
            0:       branch_target = 32'hFFFF_FFFD;
            1:       branch_target = 32'h0000_0203;
            default: branch_target = $urandom;
        endcase
        imem_ready = ($urandom_range(0, 2) != 0);
        imem_rdata = $urandom;
    endtask

    // One cycle: entered at a falling edge, leaves at the next falling edge.
    task automatic one_cycle(input int br_pct);
        randomize_inputs(br_pct);
        #1;
        check_outputs();
        model_step();
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},   32'(imem_req),    32'h0);
        check({tag, "_addr"},  imem_addr,        RST_PC);
        check({tag, "_pc"},    if_id_pc,         32'h0);
        check({tag, "_instr"}, if_id_instr,      NOP_I);
        check({tag, "_valid"}, 32'(if_id_valid), 32'h0);
    endtask

    initial begin
        bit found;
        rst_n          = 1'b0;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        imem_rdata     = 32'h0;
        imem_ready     = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with no stalls or redirects.
        for (int i = 0; i < 6; i++) begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            branch_taken   = 1'b0;
            imem_ready     = 1'b1;
            imem_rdata     = $urandom;
            #1;
            check_outputs();
            model_step();
            @(negedge clk);
        end

        // Mixed random traffic.
        for (int i = 0; i < 1500; i++) one_cycle(10);

        // Drive into a pending redirect, then reset asynchronously mid-cycle.
        for (int r = 0; r < 3; r++) begin
            found = 0;
            for (int i = 0; i < 2000 && !found; i++) begin
                one_cycle(15);
                found = m_redirect;
            end
            check("discard_reached", 32'(found), 32'h1);
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_values("async_rst");
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 300; i++) one_cycle(10);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
